// File: rtl/conv3x3_stream_engine_if.sv
// Handshake bundle for the 3x3 convolution engine: window input, result output and beat counter.
// Coefficient write and shift ports exist only when CONV_PROG_KERNEL_EN is defined.
interface conv3x3_stream_engine_if #(
    parameter int PIX_W  = 8,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 32
`ifdef CONV_PROG_KERNEL_EN
    ,
    parameter int COEF_W = 8
`endif
);
    logic [2:0]              cfg_mode;
    logic [9*PIX_W-1:0]      in_pixels;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_W-1:0]        beat_cnt;
`ifdef CONV_PROG_KERNEL_EN
    logic                     coef_wr_en;
    logic [3:0]               coef_wr_addr;
    logic signed [COEF_W-1:0] coef_wr_data;
    logic [3:0]               norm_shift;

    modport master (
        output cfg_mode, in_pixels, in_valid, out_ready,
               coef_wr_en, coef_wr_addr, coef_wr_data, norm_shift,
        input  in_ready, out_data, out_sat, out_valid, beat_cnt
    );
    modport slave (
        input  cfg_mode, in_pixels, in_valid, out_ready,
               coef_wr_en, coef_wr_addr, coef_wr_data, norm_shift,
        output in_ready, out_data, out_sat, out_valid, beat_cnt
    );
`else
    modport master (
        output cfg_mode, in_pixels, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid, beat_cnt
    );
    modport slave (
        input  cfg_mode, in_pixels, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid, beat_cnt
    );
`endif
endinterface

// File: rtl/conv3x3_stream_engine.sv
// Three-stage (multiply / adder tree / normalise+saturate) 3x3 convolution engine, one window per cycle.
// Optional programmable kernel (mode 4) is enabled by defining CONV_PROG_KERNEL_EN.
module conv3x3_stream_engine #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 32
) (
    input logic                     clk,
    input logic                     rst,
    conv3x3_stream_engine_if.slave  bus
);
    localparam int ACC_W = PIX_W + COEF_W + 5;
    localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam coef_t C_ZERO  = {COEF_W{1'b0}};
    localparam coef_t C_ONE   = {{(COEF_W-1){1'b0}}, 1'b1};
    localparam coef_t C_TWO   = COEF_W'(2'd2);
    localparam coef_t C_FOUR  = COEF_W'(3'd4);
    localparam coef_t C_EIGHT = COEF_W'(4'd8);
    localparam coef_t C_NEG1  = {COEF_W{1'b1}};
    localparam acc_t  L_NINE  = ACC_W'(4'd9);
    localparam logic signed [EXT_W-1:0] L_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] L_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Fixed kernels; unused modes fall through to centre-pixel passthrough (coefficient 1 at k=4).
    function automatic coef_t fixed_coef(input logic [2:0] mode, input logic [3:0] k);
        logic is_centre;
        logic is_edge;
        is_centre = (k == 4'd4);
        is_edge   = (k == 4'd1) || (k == 4'd3) || (k == 4'd5) || (k == 4'd7);
        case (mode)
            3'd0:    return is_centre ? C_FOUR : (is_edge ? C_NEG1 : C_ZERO);
            3'd1:    return is_centre ? C_EIGHT : C_NEG1;
            3'd2:    return is_centre ? C_FOUR : (is_edge ? C_TWO : C_ONE);
            3'd3:    return C_ONE;
            default: return is_centre ? C_ONE : C_ZERO;
        endcase
    endfunction

    logic                    w_adv;
    logic                    w_accept;
    coef_t                   w_coef [9];
    acc_t                    w_prod [9];
    acc_t                    w_sum;
    acc_t                    w_norm;
    logic signed [EXT_W-1:0] w_norm_ext;
    logic signed [OUT_W-1:0] w_clip;
    logic                    w_clip_sat;

    logic                    r_s1_valid;
    acc_t                    r_s1_prod [9];
    logic [2:0]              r_s1_mode;
    logic                    r_s2_valid;
    acc_t                    r_s2_acc;
    logic [2:0]              r_s2_mode;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_sat;
    logic [CNT_W-1:0]        r_beat_cnt;
`ifdef CONV_PROG_KERNEL_EN
    coef_t                   r_coef [9];
    logic [3:0]              r_s1_shift;
    logic [3:0]              r_s2_shift;
`endif

    assign w_adv    = !r_out_valid || bus.out_ready;
    assign w_accept = bus.in_valid && w_adv;

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign bus.beat_cnt  = r_beat_cnt;

    // S1 products: pixel zero-extended, coefficient sign-extended, both to ACC_W before multiplying.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
`ifdef CONV_PROG_KERNEL_EN
            if (bus.cfg_mode == 3'd4) begin
                w_coef[k] = r_coef[k];
            end else begin
                w_coef[k] = fixed_coef(bus.cfg_mode, 4'(k));
            end
`else
            w_coef[k] = fixed_coef(bus.cfg_mode, 4'(k));
`endif
            w_prod[k] = acc_t'(bus.in_pixels[k*PIX_W +: PIX_W]) * acc_t'(w_coef[k]);
        end
    end

    // S2 adder tree over the nine registered products.
    always_comb begin
        w_sum = {ACC_W{1'b0}};
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + r_s1_prod[k];
        end
    end

    // S3 normalise per mode, then clip to the signed OUT_W range.
    always_comb begin
        w_norm = r_s2_acc;
        case (r_s2_mode)
            3'd2:    w_norm = r_s2_acc >>> 3'd4;
            3'd3:    w_norm = r_s2_acc / L_NINE;
`ifdef CONV_PROG_KERNEL_EN
            3'd4:    w_norm = r_s2_acc >>> r_s2_shift;
`endif
            default: w_norm = r_s2_acc;
        endcase
        w_norm_ext = EXT_W'(w_norm);
        if (w_norm_ext > L_MAX) begin
            w_clip     = {1'b0, {(OUT_W-1){1'b1}}};
            w_clip_sat = 1'b1;
        end else if (w_norm_ext < L_MIN) begin
            w_clip     = {1'b1, {(OUT_W-1){1'b0}}};
            w_clip_sat = 1'b1;
        end else begin
            w_clip     = w_norm_ext[OUT_W-1:0];
            w_clip_sat = 1'b0;
        end
    end

    // Pipeline registers; every stage shifts together on w_adv so results hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 3'd0;
            r_s2_valid  <= 1'b0;
            r_s2_acc    <= {ACC_W{1'b0}};
            r_s2_mode   <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= {OUT_W{1'b0}};
            r_out_sat   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_s1_prod[k] <= {ACC_W{1'b0}};
            end
        end else if (w_adv) begin
            r_s1_valid  <= bus.in_valid;
            r_s1_prod   <= w_prod;
            r_s1_mode   <= bus.cfg_mode;
            r_s2_valid  <= r_s1_valid;
            r_s2_acc    <= w_sum;
            r_s2_mode   <= r_s1_mode;
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_data <= w_clip;
                r_out_sat  <= w_clip_sat;
            end
        end
    end

    // Accepted-beat counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef CONV_PROG_KERNEL_EN
    // Coefficient bank and per-beat shift; a write is visible to the next beat entering S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_shift <= 4'd0;
            r_s2_shift <= 4'd0;
            for (int k = 0; k < 9; k++) begin
                r_coef[k] <= C_ZERO;
            end
        end else begin
            if (bus.coef_wr_en && (bus.coef_wr_addr < 4'd9)) begin
                r_coef[bus.coef_wr_addr] <= bus.coef_wr_data;
            end
            if (w_adv) begin
                r_s1_shift <= bus.norm_shift;
                r_s2_shift <= r_s1_shift;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Self-checking bench for conv3x3_stream_engine: queue-based reference model plus directed literal cases.
module tb_conv3x3_stream_engine;
    typedef struct packed { int d; logic s; } res_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   mcnt  = 0;
    int   nout  = 0;
    int   last_out = 0;
    res_t q[$];
    int   model_coef [0:8];
    int   K [0:7][0:8] = '{'{0,-1,0,-1,4,-1,0,-1,0}, '{-1,-1,-1,-1,8,-1,-1,-1,-1},
                           '{1,2,1,2,4,2,1,2,1},     '{1,1,1,1,1,1,1,1,1},
                           '{0,0,0,0,1,0,0,0,0},     '{0,0,0,0,1,0,0,0,0},
                           '{0,0,0,0,1,0,0,0,0},     '{0,0,0,0,1,0,0,0,0}};

`ifdef CONV_PROG_KERNEL_EN
    conv3x3_stream_engine_if #(.PIX_W(8), .OUT_W(16), .CNT_W(32), .COEF_W(8)) if1 ();
    conv3x3_stream_engine_if #(.PIX_W(8), .OUT_W(8),  .CNT_W(32), .COEF_W(8)) if2 ();
`else
    conv3x3_stream_engine_if #(.PIX_W(8), .OUT_W(16), .CNT_W(32)) if1 ();
    conv3x3_stream_engine_if #(.PIX_W(8), .OUT_W(8),  .CNT_W(32)) if2 ();
`endif

    conv3x3_stream_engine #(.PIX_W(8), .COEF_W(8), .OUT_W(16), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .bus(if1));
    conv3x3_stream_engine #(.PIX_W(8), .COEF_W(8), .OUT_W(8), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] win_c(input int c, input int o);
        logic [71:0] p;
        for (int k = 0; k < 9; k++) p[k*8 +: 8] = (k == 4) ? c[7:0] : o[7:0];
        return p;
    endfunction

    function automatic logic [71:0] win_seq(input int start);
        logic [71:0] p;
        for (int k = 0; k < 9; k++) p[k*8 +: 8] = 8'(start + k);
        return p;
    endfunction

    // Reference: plain integer convolution, division and clipping.
    function automatic res_t model_calc(input int mode, input logic [71:0] px, input int shift, input int ow);
        res_t r;
        int sum, n, lim, c;
        sum = 0;
        for (int k = 0; k < 9; k++) begin
            c = K[mode][k];
`ifdef CONV_PROG_KERNEL_EN
            if (mode == 4) c = model_coef[k];
`endif
            sum += int'(px[k*8 +: 8]) * c;
        end
        n = sum;
        if (mode == 2) n = sum >>> 4;
        if (mode == 3) n = sum / 9;
`ifdef CONV_PROG_KERNEL_EN
        if (mode == 4) n = sum >>> shift;
`endif
        lim = 1 << (ow - 1);
        r.s = 1'b1;
        if (n > lim - 1) r.d = lim - 1;
        else if (n < -lim) r.d = -lim;
        else begin r.d = n; r.s = 1'b0; end
        return r;
    endfunction

    // Monitor: accept pushes expected result (old coefficients), then coefficient writes apply.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                mcnt = 0;
                for (int k = 0; k < 9; k++) model_coef[k] = 0;
            end else begin
                if (if1.in_valid && if1.in_ready) begin
`ifdef CONV_PROG_KERNEL_EN
                    q.push_back(model_calc(int'(if1.cfg_mode), if1.in_pixels, int'(if1.norm_shift), 16));
`else
                    q.push_back(model_calc(int'(if1.cfg_mode), if1.in_pixels, 0, 16));
`endif
                    mcnt++;
                end
`ifdef CONV_PROG_KERNEL_EN
                if (if1.coef_wr_en && if1.coef_wr_addr < 4'd9)
                    model_coef[if1.coef_wr_addr] = int'(if1.coef_wr_data);
`endif
            end
        end
    end

    // Compare: every delivered beat against the model, hold while stalled, counter every cycle.
    initial begin
        logic held;
        int   prev_d;
        logic prev_s;
        res_t e;
        held = 1'b0; prev_d = 0; prev_s = 1'b0;
        forever begin
            @(negedge clk);
            chk("beat_cnt", int'(if1.beat_cnt), mcnt);
            if (if1.out_valid) begin
                if (held) begin
                    chk("hold_data", int'($signed(if1.out_data)), prev_d);
                    chk("hold_sat", int'(if1.out_sat), int'(prev_s));
                end
                if (if1.out_ready) begin
                    if (q.size() == 0) chk("unexpected_beat", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("stream_data", int'($signed(if1.out_data)), e.d);
                        chk("stream_sat", int'(if1.out_sat), int'(e.s));
                        last_out = int'($signed(if1.out_data));
                        nout++;
                    end
                end
                held   = !if1.out_ready;
                prev_d = int'($signed(if1.out_data));
                prev_s = if1.out_sat;
            end else begin
                if (held) chk("hold_valid", 0, 1);
                held = 1'b0;
            end
        end
    end

    task automatic send(input logic [2:0] mode, input logic [71:0] px);
        logic a;
        int   n;
        if1.cfg_mode = mode; if1.in_pixels = px; if1.in_valid = 1'b1;
        a = 1'b0;
        for (n = 0; n < 50 && !a; n++) begin
            @(negedge clk);
            a = if1.in_ready;
            @(posedge clk); #1;
        end
        if (!a) chk("send_timeout", 0, 1);
        if1.in_valid = 1'b0;
    endtask

    task automatic one(input string name, input logic [2:0] mode, input logic [71:0] px,
                       input int exp_d, input int exp_s);
        int lat;
        send(mode, px);
        lat = 0;
        while (!if1.out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        chk({name, "_lat"}, lat, 2);
        chk({name, "_data"}, int'($signed(if1.out_data)), exp_d);
        chk({name, "_sat"}, int'(if1.out_sat), exp_s);
        @(posedge clk); #1;
    endtask

    task automatic one2(input string name, input logic [2:0] mode, input logic [71:0] px,
                        input int exp_d, input int exp_s);
        chk({name, "_rdy"}, int'(if2.in_ready), 1);
        if2.cfg_mode = mode; if2.in_pixels = px; if2.in_valid = 1'b1;
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk({name, "_vld"}, int'(if2.out_valid), 1);
        chk({name, "_data"}, int'($signed(if2.out_data)), exp_d);
        chk({name, "_sat"}, int'(if2.out_sat), exp_s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 60 && (q.size() != 0 || if1.out_valid); n++) begin @(posedge clk); #1; end
        if (q.size() != 0 || if1.out_valid) chk("drain_timeout", 0, 1);
    endtask

`ifdef CONV_PROG_KERNEL_EN
    task automatic wr_coef(input int addr, input int data);
        if1.coef_wr_en = 1'b1; if1.coef_wr_addr = 4'(addr); if1.coef_wr_data = 8'(data);
        @(posedge clk); #1;
        if1.coef_wr_en = 1'b0;
    endtask
`endif

    initial begin
        int n0, v;
        res_t r;
        rst = 1'b1;
        if1.cfg_mode = 3'd0; if1.in_pixels = '0; if1.in_valid = 1'b0; if1.out_ready = 1'b1;
        if2.cfg_mode = 3'd0; if2.in_pixels = '0; if2.in_valid = 1'b0; if2.out_ready = 1'b1;
`ifdef CONV_PROG_KERNEL_EN
        if1.coef_wr_en = 1'b0; if1.coef_wr_addr = 4'd0; if1.coef_wr_data = 8'd0; if1.norm_shift = 4'd0;
        if2.coef_wr_en = 1'b0; if2.coef_wr_addr = 4'd0; if2.coef_wr_data = 8'd0; if2.norm_shift = 4'd0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", int'(if1.out_valid), 0);
        chk("rst_data", int'(if1.out_data), 0);
        chk("rst_sat", int'(if1.out_sat), 0);
        chk("rst_cnt", int'(if1.beat_cnt), 0);
        chk("rst_ready", int'(if1.in_ready), 1);

        r = model_calc(0, win_c(255, 0), 0, 16);   chk("pin_m0", r.d, 1020);
        r = model_calc(1, win_c(0, 255), 0, 16);   chk("pin_m1", r.d, -2040);
        r = model_calc(1, win_c(0, 255), 0, 8);    chk("pin_m1_w8", r.d, -128); chk("pin_m1_w8s", int'(r.s), 1);
        r = model_calc(2, win_c(16, 16), 0, 16);   chk("pin_m2", r.d, 16);
        r = model_calc(3, win_seq(1), 0, 16);      chk("pin_m3", r.d, 5);
        r = model_calc(6, win_c(77, 200), 0, 16);  chk("pin_m6", r.d, 77);

        one("m0", 3'd0, win_c(255, 0), 1020, 0);
        one("m1", 3'd1, win_c(0, 255), -2040, 0);
        one("m2", 3'd2, win_c(16, 16), 16, 0);
        one("m3", 3'd3, win_seq(1), 5, 0);
        one("m6", 3'd6, win_c(77, 200), 77, 0);
        one("m3_big", 3'd3, win_c(255, 255), 255, 0);
`ifndef CONV_PROG_KERNEL_EN
        one("m4_pass", 3'd4, win_c(33, 99), 33, 0);
`endif
        one2("w8_m1", 3'd1, win_c(0, 255), -128, 1);
        one2("w8_m0", 3'd0, win_c(255, 0), 127, 1);
        one2("w8_m3", 3'd3, win_seq(1), 5, 0);

        // Back-to-back stream with a 4-cycle downstream stall
        do_reset();
        n0 = nout;
        fork
            begin
                send(3'd0, win_c(200, 10));
                send(3'd3, win_seq(100));
                send(3'd0, win_c(5, 60));
                send(3'd3, win_seq(1));
                send(3'd0, win_seq(0));
                send(3'd3, win_c(255, 255));
            end
            begin
                repeat (3) @(posedge clk);
                #1 if1.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 if1.out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", nout - n0, 6);
        chk("stream_cnt6", int'(if1.beat_cnt), 6);
        chk("stream_last", last_out, 255);

        // Reset with two beats in flight
        send(3'd0, win_c(255, 0));
        send(3'd1, win_c(0, 255));
        do_reset();
        chk("rst2_valid", int'(if1.out_valid), 0);
        chk("rst2_cnt", int'(if1.beat_cnt), 0);
        v = 0;
        repeat (6) begin @(posedge clk); #1; if (if1.out_valid) v++; end
        chk("rst2_stale", v, 0);

`ifdef CONV_PROG_KERNEL_EN
        for (int a = 0; a < 9; a++) wr_coef(a, (a == 4) ? 3 : 0);
        wr_coef(9, 7);
        if1.norm_shift = 4'd1;
        one("prog15", 3'd4, win_c(10, 0), 15, 0);
        if1.out_ready = 1'b0;
        send(3'd4, win_c(10, 0));
        v = 0;
        while (!if1.out_valid && v < 10) begin @(posedge clk); #1; v++; end
        chk("prog_held", int'($signed(if1.out_data)), 15);
        chk("prog_stall_rdy", int'(if1.in_ready), 0);
        wr_coef(4, -1);
        fork
            send(3'd4, win_c(10, 0));
            begin
                repeat (2) @(posedge clk);
                #1 if1.out_ready = 1'b1;
            end
        join
        drain();
        chk("prog_m5", last_out, -5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
